// File: rtl/dti_apb_master.sv
// APB4 initiator: valid/ready commands are queued in a small FIFO, issued as
// SETUP/ACCESS transfers with an ACCESS-phase timeout, and answered one response at a time.
module dti_apb_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_STRB_WIDTH = 4,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [APB_STRB_WIDTH-1:0] cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_STRB_WIDTH-1:0] pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [APB_DATA_WIDTH-1:0] prdata
);

  localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FIFO_FULL_C  = CNT_W'(CMD_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C   = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE_C    = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C   = PTR_W'(0);
  localparam logic             TIMEOUT_EN_C = (TIMEOUT_CYCLES != 0);
  // With the timeout disabled this wraps to 16'hFFFF but is never compared.
  localparam logic [15:0]      TIMEOUT_LAST_C = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [APB_DATA_WIDTH-1:0] DATA_ZERO_C = {APB_DATA_WIDTH{1'b0}};
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_ZERO_C = {APB_ADDR_WIDTH{1'b0}};
  localparam logic [APB_STRB_WIDTH-1:0] STRB_ZERO_C = {APB_STRB_WIDTH{1'b0}};

  logic                      fifo_write_r [CMD_FIFO_DEPTH];
  logic [APB_ADDR_WIDTH-1:0] fifo_addr_r  [CMD_FIFO_DEPTH];
  logic [APB_DATA_WIDTH-1:0] fifo_wdata_r [CMD_FIFO_DEPTH];
  logic [APB_STRB_WIDTH-1:0] fifo_strb_r  [CMD_FIFO_DEPTH];

  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [CNT_W-1:0]          count_r;
  logic [CNT_W-1:0]          count_s;
  logic                      cmd_ready_r;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_empty_s;

  logic                      head_write_s;
  logic [APB_ADDR_WIDTH-1:0] head_addr_s;
  logic [APB_DATA_WIDTH-1:0] head_wdata_s;
  logic [APB_STRB_WIDTH-1:0] head_strb_s;

  logic [1:0]                state_r;
  logic [1:0]                state_s;
  logic                      capture_s;
  logic                      abort_s;
  logic [15:0]               tmo_cnt_r;

  logic                      psel_r;
  logic                      penable_r;
  logic                      pwrite_r;
  logic [APB_ADDR_WIDTH-1:0] paddr_r;
  logic [APB_DATA_WIDTH-1:0] pwdata_r;
  logic [APB_STRB_WIDTH-1:0] pstrb_r;

  logic                      rsp_valid_r;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_r;
  logic                      rsp_slverr_r;
  logic                      rsp_timeout_r;

  assign push_s       = cmd_valid & cmd_ready_r;
  assign fifo_empty_s = (count_r == CNT_ZERO_C);

  assign head_write_s = fifo_write_r[rd_ptr_r];
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_wdata_s = fifo_wdata_r[rd_ptr_r];
  assign head_strb_s  = fifo_strb_r[rd_ptr_r];

  // Transfer sequencing: next state, FIFO pop and response capture/abort strobes.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A completing pready wins over a timeout landing in the same cycle.
        if (pready) begin
          capture_s = 1'b1;
          state_s   = ST_RESP;
        end else if (TIMEOUT_EN_C && (tmo_cnt_r == TIMEOUT_LAST_C)) begin
          abort_s = 1'b1;
          state_s = ST_RESP;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_s = ST_SETUP;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE_C;
      2'b01:   count_s = count_r - CNT_ONE_C;
      default: count_s = count_r;
    endcase
  end

  // Command FIFO storage, pointers, occupancy and the registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CMD_FIFO_DEPTH; i++) begin
        fifo_write_r[i] <= 1'b0;
        fifo_addr_r[i]  <= ADDR_ZERO_C;
        fifo_wdata_r[i] <= DATA_ZERO_C;
        fifo_strb_r[i]  <= STRB_ZERO_C;
      end
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      count_r     <= CNT_ZERO_C;
      cmd_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_write_r[wr_ptr_r] <= cmd_write;
        fifo_addr_r[wr_ptr_r]  <= cmd_addr;
        fifo_wdata_r[wr_ptr_r] <= cmd_wdata;
        fifo_strb_r[wr_ptr_r]  <= cmd_strb;
        wr_ptr_r               <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r     <= count_s;
      cmd_ready_r <= (count_s != FIFO_FULL_C);
    end
  end

  // FSM state, APB control/payload registers and the ACCESS timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= ADDR_ZERO_C;
      pwdata_r  <= DATA_ZERO_C;
      pstrb_r   <= STRB_ZERO_C;
      tmo_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_s;
      psel_r    <= (state_s == ST_SETUP) || (state_s == ST_ACCESS);
      penable_r <= (state_s == ST_ACCESS);
      if (pop_s) begin
        pwrite_r  <= head_write_s;
        paddr_r   <= head_addr_s;
        pwdata_r  <= head_write_s ? head_wdata_s : DATA_ZERO_C;
        pstrb_r   <= head_write_s ? head_strb_s : STRB_ZERO_C;
        tmo_cnt_r <= 16'd0;
      end else if (state_r == ST_ACCESS) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end
    end
  end

  // Single-entry response register, held stable while waiting for rsp_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= DATA_ZERO_C;
      rsp_slverr_r  <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      rsp_valid_r <= (state_s == ST_RESP);
      if (capture_s) begin
        rsp_rdata_r   <= pwrite_r ? DATA_ZERO_C : prdata;
        rsp_slverr_r  <= pslverr;
        rsp_timeout_r <= 1'b0;
      end else if (abort_s) begin
        rsp_rdata_r   <= DATA_ZERO_C;
        rsp_slverr_r  <= 1'b1;
        rsp_timeout_r <= 1'b1;
      end
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_slverr  = rsp_slverr_r;
  assign rsp_timeout = rsp_timeout_r;
  assign busy        = (state_r != ST_IDLE) || !fifo_empty_s;
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = pwrite_r;
  assign paddr       = paddr_r;
  assign pwdata      = pwdata_r;
  assign pstrb       = pstrb_r;

endmodule

// File: tb/tb_dti_apb_master.sv
// Directed bench for dti_apb_master: table of single transfers plus
// hand-written queueing, timeout and mid-transfer reset sequences.
module tb_dti_apb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout, busy;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] prdata_v;
  logic        auto_mode;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_n;
    logic        slverr;
    logic [31:0] prdata;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    logic        exp_to;
  } vec_t;

  vec_t vecs [6];

  dti_apb_master #(
    .APB_ADDR_WIDTH(12),
    .APB_DATA_WIDTH(32),
    .APB_STRB_WIDTH(4),
    .CMD_FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata)
  );

  always #5 clk = ~clk;

  // In auto mode the slave returns a data word tagged with the address.
  always_comb prdata = auto_mode ? {20'hABCDE, paddr} : prdata_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs_zero",
          {31'd0, |{cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
                    psel, penable, pwrite, paddr, pwdata, pstrb}}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t;
    int n;
    bit stable;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("v%0d_cmd_ready", idx), {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!psel && t < 20) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("v%0d_setup_psel", idx), {31'd0, psel}, 32'd1);
    check($sformatf("v%0d_setup_penable", idx), {31'd0, penable}, 32'd0);
    check($sformatf("v%0d_paddr", idx), {20'd0, paddr}, {20'd0, v.addr});
    check($sformatf("v%0d_pwrite", idx), {31'd0, pwrite}, {31'd0, v.write});
    check($sformatf("v%0d_pwdata", idx), pwdata, v.exp_pwdata);
    check($sformatf("v%0d_pstrb", idx), {28'd0, pstrb}, {28'd0, v.exp_pstrb});
    @(negedge clk);
    n = 0;
    stable = 1'b1;
    while (psel && penable && n < 20) begin
      n++;
      if (paddr !== v.addr || pwrite !== v.write || pwdata !== v.exp_pwdata ||
          pstrb !== v.exp_pstrb)
        stable = 1'b0;
      pready   = (n == v.wait_n + 1);
      pslverr  = pready & v.slverr;
      prdata_v = pready ? v.prdata : 32'hFFFF_FFFF;
      @(negedge clk);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    check($sformatf("v%0d_access_cycles", idx), n, v.exp_acc);
    check($sformatf("v%0d_payload_stable", idx), {31'd0, stable}, 32'd1);
    check($sformatf("v%0d_resp_psel_off", idx), {30'd0, psel, penable}, 32'd0);
    check($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
    check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_rsp_slverr", idx), {31'd0, rsp_slverr}, {31'd0, v.exp_slverr});
    check($sformatf("v%0d_rsp_timeout", idx), {31'd0, rsp_timeout}, {31'd0, v.exp_to});
    @(negedge clk);
    check($sformatf("v%0d_rsp_held", idx), {31'd0, rsp_valid}, 32'd1);
    check($sformatf("v%0d_rsp_rdata_held", idx), rsp_rdata, v.exp_rdata);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_done", idx), {31'd0, rsp_valid}, 32'd0);
    check($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "global time limit expired");
  end

  initial begin
    logic [31:0] exp_q [6];
    int  got;
    int  cyc;
    bit  acc;

    vecs[0] = '{1'b1, 12'h008, 32'h0000_00A5, 4'hF, 0,  1'b0, 32'hFFFF_FFFF,
                32'h0000_00A5, 4'hF, 1, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 12'h00C, 32'hDEAD_BEEF, 4'hF, 3,  1'b0, 32'h1234_5678,
                32'h0, 4'h0, 4, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 12'h010, 32'h0, 4'h0, 1,  1'b1, 32'hCAFE_0001,
                32'h0, 4'h0, 2, 32'hCAFE_0001, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 12'h014, 32'h0, 4'h0, 99, 1'b0, 32'h0,
                32'h0, 4'h0, 4, 32'h0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 12'h018, 32'h55AA_55AA, 4'h3, 2,  1'b1, 32'hFFFF_FFFF,
                32'h55AA_55AA, 4'h3, 3, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 12'h01C, 32'h0, 4'h0, 0,  1'b0, 32'h0BAD_F00D,
                32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_wdata = 32'h0;
    cmd_strb = 4'h0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    prdata_v = 32'h0; auto_mode = 1'b0;

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Six back-to-back commands with responses stalled; odd entries are writes.
    do_reset();
    auto_mode = 1'b1;
    pready    = 1'b1;
    for (int i = 0; i < 6; i++)
      exp_q[i] = (i % 2 == 1) ? 32'h0 : {20'hABCDE, 12'h100 + 12'(4 * i)};
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_write = (i % 2 == 1);
      cmd_addr  = 12'h100 + 12'(4 * i);
      cmd_wdata = 32'h1000 + 32'(i);
      cmd_strb  = 4'hF;
      cyc = 0;
      while (!cmd_ready && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
    end
    cmd_write = 1'b1;
    cmd_addr  = 12'h114;
    cmd_wdata = 32'h1005;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("q_full_ready_low_%0d", k), {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    check("q_first_rsp_waiting", {31'd0, rsp_valid}, 32'd1);
    check("q_busy", {31'd0, busy}, 32'd1);
    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 100) begin
      acc = cmd_valid && cmd_ready;
      if (cyc == 0) check("q_ready_low_in_pop_cycle", {31'd0, cmd_ready}, 32'd0);
      if (cyc == 1) check("q_ready_rises_next_cycle", {31'd0, cmd_ready}, 32'd1);
      if (rsp_valid) begin
        check($sformatf("q_rsp%0d_rdata", got), rsp_rdata, exp_q[got]);
        check($sformatf("q_rsp%0d_slverr", got), {31'd0, rsp_slverr}, 32'd0);
        got++;
      end
      @(negedge clk);
      if (acc) cmd_valid = 1'b0;
      cyc++;
    end
    check("q_all_responses", got, 6);
    rsp_ready = 1'b0;
    pready    = 1'b0;
    auto_mode = 1'b0;
    @(negedge clk);
    check("q_idle_busy", {31'd0, busy}, 32'd0);

    // Reset while a read sits in ACCESS with a second command queued.
    do_reset();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; cmd_strb = 4'h0;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 12'h044; cmd_wdata = 32'h0000_0077; cmd_strb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!penable && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_in_access", {30'd0, psel, penable}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_psel_penable", {30'd0, psel, penable}, 32'd0);
    check("rst_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after_release", {31'd0, cmd_ready}, 32'd1);
    check("rst_fifo_empty", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_no_stale_transfer", {31'd0, psel}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dti_apb_master.md
Name: dti_apb_master

Overview:
- APB initiator for the peripheral subsystem. It converts a simple valid/ready command stream into APB4 setup/access transfers and returns one response per command.
- Used by the debug/boot controller to program and poll APB peripherals such as the UART register block.
- Contains a small command FIFO, a transfer FSM, a single-entry response register and a transfer timeout.

Parameters:
- APB_ADDR_WIDTH, 12: paddr / cmd_addr width.
- APB_DATA_WIDTH, 32: pwdata / prdata / cmd_wdata / rsp_rdata width.
- APB_STRB_WIDTH, 4: pstrb / cmd_strb width; equals APB_DATA_WIDTH/8.
- CMD_FIFO_DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 255: maximum cycles spent in ACCESS before abort. 0 disables the timeout. Range 0..65535.

Ports:
- clk  in  1  clock for all logic, including the APB side.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  APB_ADDR_WIDTH  transfer address.
- cmd_wdata  in  APB_DATA_WIDTH  write data.
- cmd_strb  in  APB_STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_slverr  out  1  pslverr was sampled, or the transfer timed out.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  APB_ADDR_WIDTH  APB address.
- pwdata  out  APB_DATA_WIDTH  APB write data.
- pstrb  out  APB_STRB_WIDTH  APB strobes.
- pready, pslverr  in  1 each  APB completion.
- prdata  in  APB_DATA_WIDTH  APB read data.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0.
  - Reset asserted mid-transfer drops psel/penable asynchronously.
  - Any pending response is discarded.
- FIFO:
  - cmd_ready = !full, registered.
  - Push and pop in the same cycle are allowed.
  - When full, cmd_ready stays 0 in the same cycle as a pop; it rises the following cycle.
  - Pointers wrap modulo CMD_FIFO_DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE -> SETUP when the FIFO is not empty. The head entry is popped, and paddr/pwrite/pwdata/pstrb are registered.
    - pstrb is forced to 0 for reads.
    - pwdata is forced to 0 for reads.
  - SETUP: psel=1, penable=0. Always -> ACCESS next cycle.
  - ACCESS: psel=1, penable=1; the timeout counter increments each cycle.
    - If pready=1: capture prdata (reads only, else 0) and pslverr into the response register, then -> RESP.
    - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: abort. Response is rdata=0, slverr=1, timeout=1; -> RESP.
    - pready has priority over timeout in the same cycle.
  - RESP: psel=0, penable=0, rsp_valid=1, held with stable data until rsp_ready.
    - On handshake: -> SETUP directly if the FIFO is not empty (pop as in IDLE), else -> IDLE.
- Counter: cleared on entering SETUP. Counts 1 in the first ACCESS cycle. 16-bit.
- APB rules:
  - paddr/pwrite/pwdata/pstrb are stable from SETUP through the last ACCESS cycle.
  - Outside a transfer they hold their last value; psel=0 and penable=0.
  - penable is never 1 without psel.
- Latency:
  - Command push to SETUP: at least 2 cycles (FIFO write, then IDLE pop).
  - With zero wait states, rsp_valid rises 2 cycles after SETUP.
  - Steady-state throughput with rsp_ready held at 1 is one transfer per 3 cycles.
- busy is combinational from state and FIFO occupancy.

Test Plan:
- Write addr 0x008, data 0x0000_00A5, strb 0xF, pready=1 immediately -> one SETUP and one ACCESS cycle with pwrite=1, pstrb=0xF. Response rdata=0, slverr=0, timeout=0.
- Read addr 0x00C, pready delayed 3 cycles, prdata=0x1234_5678 -> 4 ACCESS cycles; pstrb=0 and pwdata=0 throughout. Response rdata=0x1234_5678.
- Read with pslverr=1 at pready -> rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=4, pready stuck 0 -> abort after exactly 4 ACCESS cycles, psel drops. Response slverr=1, timeout=1, rdata=0. The next queued command then runs normally.
- Push 6 commands back-to-back with rsp_ready=0 -> the first pops to the bus, 4 fill the FIFO, cmd_ready=0 until the first response is accepted. All 6 complete in order.
- Assert reset during ACCESS -> psel/penable/rsp_valid go 0 immediately, FIFO empties, cmd_ready=1 the cycle after reset release.
